// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, selectable shift order,
// optional parity slot and back-to-back frames paced by the EN bit tick.
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int PARITY    = 0,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         LOAD_VALID,
  output logic         LOAD_READY,
  input  logic [N-1:0] DATAW,
  output logic         SOUT,
  output logic         SVALID,
  output logic         BUSY,
  output logic         DONE
);

  localparam int F  = N + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;
  logic          sout_q, sout_d;
  logic          svalid_q, svalid_d;
  logic          done_q, done_d;

  logic          last_slot;
  logic          frame_end;
  logic          load;
  logic [N-1:0]  shreg_next;

  function automatic logic first_bit(input logic [N-1:0] w);
    return MSB_FIRST ? w[N-1] : w[0];
  endfunction

  // Ready opens on the EN edge that closes the last slot, so frames chain without a gap.
  always_comb begin
    last_slot  = (state_q == S_PAR) ||
                 ((state_q == S_SHIFT) && (cnt_q == LAST_DATA) && (PARITY == 0));
    frame_end  = last_slot && EN;
    LOAD_READY = (state_q == S_IDLE) || frame_end;
    load       = LOAD_VALID && LOAD_READY;
    shreg_next = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    sout_d   = sout_q;
    svalid_d = svalid_q;
    done_d   = 1'b0;

    if (load) begin
      state_d  = S_SHIFT;
      shreg_d  = DATAW;
      cnt_d    = '0;
      par_d    = (^DATAW) ^ (PARITY == 2);
      sout_d   = first_bit(DATAW);
      svalid_d = 1'b1;
      done_d   = frame_end;
    end else if (frame_end) begin
      state_d  = S_IDLE;
      shreg_d  = '0;
      cnt_d    = '0;
      sout_d   = IDLE_LVL;
      svalid_d = 1'b0;
      done_d   = 1'b1;
    end else if (EN && (state_q == S_SHIFT)) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_DATA) begin
        state_d = S_PAR;
        sout_d  = par_q;
      end else begin
        shreg_d = shreg_next;
        sout_d  = first_bit(shreg_next);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      sout_q   <= IDLE_LVL;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  assign SOUT   = sout_q;
  assign SVALID = svalid_q;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: three serializer configurations share stimulus; each has a
// slot-counting reference model feeding an expected-bit queue and a negedge monitor.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load_valid;
  logic [7:0] dataw;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LSB first, no parity, idle 0. Instance 1: MSB first, even parity,
  // idle 1. Instance 2: LSB first, odd parity, idle 0.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit MSB = (g == 1);
    localparam int PAR = g;
    localparam bit IDL = (g == 1);
    localparam int F   = 8 + ((PAR != 0) ? 1 : 0);

    logic ready, sout, svalid, busy, done;

    piso_serializer #(.N(8), .MSB_FIRST(MSB), .PARITY(PAR), .IDLE_LVL(IDL)) u_dut (
      .CLK       (clk),
      .RESET     (rst),
      .EN        (en),
      .LOAD_VALID(load_valid),
      .LOAD_READY(ready),
      .DATAW     (dataw),
      .SOUT      (sout),
      .SVALID    (svalid),
      .BUSY      (busy),
      .DONE      (done)
    );

    bit q[$];
    int rem      = 0;
    bit exp_done = 1'b0;
    bit hs;

    // Model: rem = frame slots still to be sent; a handshake queues the whole frame.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        rem      = 0;
        exp_done = 1'b0;
      end else begin
        hs       = load_valid && ((rem == 0) || ((rem == 1) && en));
        exp_done = (rem == 1) && en;
        if ((rem > 0) && en) rem--;
        if (hs) begin
          for (int i = 0; i < 8; i++) q.push_back(MSB ? dataw[7-i] : dataw[i]);
          if (PAR != 0) q.push_back((($countones(dataw) % 2) == 1) ^ (PAR == 2));
          rem = F;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("u%0d ready", g), ready, (rem == 0) || ((rem == 1) && en));
      check($sformatf("u%0d svalid", g), svalid, rem > 0);
      check($sformatf("u%0d busy", g), busy, rem > 0);
      check($sformatf("u%0d done", g), done, exp_done);
      check($sformatf("u%0d qsize", g), q.size(), rem);
      if (q.size() > 0) begin
        check($sformatf("u%0d sout", g), sout, q[0]);
        if (en) void'(q.pop_front());
      end else begin
        check($sformatf("u%0d idle", g), sout, IDL);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    dataw      = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    dataw      = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic frame at full bit rate.
    en = 1'b1;
    load_word(8'hC4);
    repeat (12) tick();

    // Bit tick every third cycle.
    en = 1'b0;
    load_word(8'h81);
    for (int i = 0; i < 30; i++) begin
      en = (i % 3 == 2);
      tick();
    end
    en = 1'b1;
    repeat (6) tick();

    // Back-to-back frames with valid held high.
    dataw      = 8'hF0;
    load_valid = 1'b1;
    tick();
    dataw = 8'h0F;
    repeat (9) tick();
    load_valid = 1'b0;
    repeat (20) tick();

    // Valid pulse while busy is ignored.
    load_word(8'h3C);
    repeat (3) tick();
    load_word(8'hFF);
    repeat (12) tick();

    // Asynchronous reset mid-frame, then a clean frame.
    load_word(8'hAA);
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    check("t5 u0 sout", g_dut[0].sout, 1'b0);
    check("t5 u0 svalid", g_dut[0].svalid, 1'b0);
    check("t5 u0 busy", g_dut[0].busy, 1'b0);
    check("t5 u1 sout", g_dut[1].sout, 1'b1);
    check("t5 u1 busy", g_dut[1].busy, 1'b0);
    check("t5 u2 done", g_dut[2].done, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    load_word(8'h55);
    repeat (12) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(3) != 0);
      load_valid = ($urandom_range(2) == 0);
      dataw      = 8'($urandom);
      tick();
    end

    load_valid = 1'b0;
    en         = 1'b1;
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
